cpu_wrqueue: RTL and testbench
==============================

Name: cpu_wrqueue

Overview:
- Sits between the CPU bus snoop and the VRAM port, in the pixClk domain.
- Captures 68000 write cycles that hit the Mac SE main screen buffer and converts the 16-bit word plus UDS/LDS into 8-bit VRAM byte writes.
- Queues captured writes in a small FIFO and drains them only inside the CPU write slot of the 8-pixel hCount[2:0] sequence, so the slot never collides with video fetches.

Parameters:
- FB_BASE, 24'h3FA700, byte address of the main screen buffer (4 MB SE).
- FB_BYTES, 21888, screen buffer size in bytes (512x342 pixels, 1 bpp).
- DEPTH, 4, number of FIFO word entries (power of 2, at least 2).
- VRAM_AW, 15, VRAM byte address width.
- WR_SLOT, 3'd4, sequence value that opens the write slot (must be 0..4).

Ports:
- pixClk  in  1  25.175 MHz pixel clock; the only clock.
- nReset  in  1  asynchronous active-low reset.
- sequence  in  3  hCount[2:0] from the timing generator.
- cpuAddr  in  23  CPU address bus A23:A1.
- cpuData  in  16  CPU data bus.
- ncpuAS  in  1  address strobe, active low, asynchronous to pixClk.
- ncpuUDS  in  1  upper data strobe (D15:8, even byte), active low.
- ncpuLDS  in  1  lower data strobe (D7:0, odd byte), active low.
- cpuRnW  in  1  1 = read, 0 = write.
- vramAddr  out  VRAM_AW  VRAM byte address.
- vramData  out  8  VRAM write data.
- vramDataOE  out  1  high = block drives the VRAM data bus.
- nvramWE  out  1  VRAM write strobe, active low.
- qFull  out  1  FIFO holds DEPTH entries.
- qOverflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (asynchronous, any time, including mid-write):
  - vramAddr=0, vramData=0, vramDataOE=0, nvramWE=1.
  - qFull=0, qOverflow=0, FIFO empty, drain FSM in IDLE, capture re-armed.
- Synchronisation: ncpuAS, ncpuUDS and ncpuLDS each pass through a 2-flop synchroniser. cpuAddr, cpuData and cpuRnW are sampled raw at the capture edge; they are stable while the strobes are asserted.
- Capture condition (evaluated on synchronised signals): AS low, and UDS or LDS low, and cpuRnW=0, and window hit, and capture armed.
  - At the capture edge, push {offset, data, ub, lb} and disarm.
  - Re-arm when synchronised AS returns high. Result: exactly one push per bus cycle.
- Address decode:
  - byteAddr = {cpuAddr, 1'b0}.
  - Hit when FB_BASE <= byteAddr < FB_BASE+FB_BYTES.
  - offset = (byteAddr - FB_BASE) truncated to VRAM_AW bits.
- Byte split:
  - ub only: one write, data[15:8] to offset.
  - lb only: one write, data[7:0] to offset+1.
  - Both: two writes, upper byte first, in consecutive sequence periods.
- Drain FSM states: IDLE, SETUP, STROBE, HOLD. Outputs are registered and change on the edge at which the sequence input equals the value given.
  - IDLE -> SETUP at edge with sequence==WR_SLOT and FIFO non-empty: load vramAddr and vramData, set vramDataOE=1.
  - SETUP -> STROBE at edge with sequence==WR_SLOT+1: nvramWE=0.
  - STROBE -> HOLD at edge with sequence==WR_SLOT+2: nvramWE=1.
  - HOLD -> IDLE at edge with sequence==WR_SLOT+3: vramDataOE=0, byte retired.
  - The FIFO entry is popped when its last byte retires.
- Throughput: at most one byte per 8-cycle sequence period. nvramWE low for exactly 1 pixClk.
- FIFO:
  - qFull = (count==DEPTH).
  - Push while full with a pop on the same edge: accepted.
  - Push while full with no pop: entry dropped, qOverflow set; qOverflow clears only on reset.
  - Push and pop on the same edge while not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: capture occurs 3 pixClk after the first strobe-low edge; the first byte enters SETUP at the next WR_SLOT edge with the FIFO non-empty.

Optional Feature:
- Macro: SEVGA_ALTBUF_EN.
- Defined:
  - A second window at FB_BASE-24'h008000 of FB_BYTES is also decoded.
  - vramAddr widens to VRAM_AW+1; its MSB = 1 for alt-window hits and 0 for main-window hits; the lower bits carry the offset from the matching base.
  - The entry stores the window bit.
- Undefined: only the main window is decoded and vramAddr is VRAM_AW bits wide.

Test Plan:
- Word write: cpuAddr=23'h1FD380, data 16'hA55A, UDS+LDS low, RnW=0 -> write 8'hA5 to 15'h0000, then 8'h5A to 15'h0001 one sequence period later; each nvramWE pulse is 1 pixClk, inside vramDataOE high.
- LDS-only write: cpuAddr=23'h1FD381, data 16'h12C3 -> single write of 8'hC3 to 15'h0003.
- Window bounds:
  - Byte address 24'h3FA6FE (below base): no write.
  - Byte address 24'h3FFC80 (base+FB_BYTES): no write.
  - Byte address 24'h3FFC7E, UDS only: write to 15'h557E.
  - Read cycle (RnW=1) in window: no write.
- Overflow: hold sequence at 0, issue 5 in-window word writes -> qFull=1 after the 4th, 5th dropped, qOverflow=1; then run sequence -> 8 byte writes in original order, qFull=0, qOverflow stays 1.
- Long AS: strobes held low for 40 pixClk -> exactly one push.
- Reset mid-write: drop nReset while nvramWE=0 -> nvramWE=1 and vramDataOE=0 immediately (no clock edge needed), FIFO empty after release.

Source files
------------

// File: rtl/cpu_wrqueue.sv
// cpu_wrqueue: captures 68000 writes to the SE screen buffer and replays them as VRAM byte writes
// inside the CPU slot of hCount[2:0]. Optional alternate buffer window: SEVGA_ALTBUF_EN.
module cpu_wrqueue #(
  parameter logic [23:0] FB_BASE  = 24'h3FA700,
  parameter int          FB_BYTES = 21888,
  parameter int          DEPTH    = 4,
  parameter int          VRAM_AW  = 15,
  parameter logic [2:0]  WR_SLOT  = 3'd4
) (
  input  logic               pixClk,
  input  logic               nReset,
  // hCount[2:0]; named hSeq because "sequence" is a reserved word
  input  logic [2:0]         hSeq,
  input  logic [22:0]        cpuAddr,
  input  logic [15:0]        cpuData,
  input  logic               ncpuAS,
  input  logic               ncpuUDS,
  input  logic               ncpuLDS,
  input  logic               cpuRnW,
`ifdef SEVGA_ALTBUF_EN
  output logic [VRAM_AW:0]   vramAddr,
`else
  output logic [VRAM_AW-1:0] vramAddr,
`endif
  output logic [7:0]         vramData,
  output logic               vramDataOE,
  output logic               nvramWE,
  output logic               qFull,
  output logic               qOverflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [24:0]  MAIN_LO = {1'b0, FB_BASE};
  localparam logic [24:0]  MAIN_HI = MAIN_LO + 25'(FB_BYTES);
  localparam logic [2:0]   SLOT1   = WR_SLOT + 3'd1;
  localparam logic [2:0]   SLOT2   = WR_SLOT + 3'd2;
  localparam logic [2:0]   SLOT3   = WR_SLOT + 3'd3;
`ifdef SEVGA_ALTBUF_EN
  localparam logic [24:0]  ALT_LO  = MAIN_LO - 25'h0008000;
  localparam logic [24:0]  ALT_HI  = ALT_LO + 25'(FB_BYTES);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} drainState_t;

  logic asMeta, asSync, udsMeta, udsSync, ldsMeta, ldsSync;
  logic armed;
  logic [24:0] byteAddr;
  logic winHit, capture;
  logic [VRAM_AW-1:0] capOffset;
  logic capAlt;

  logic [VRAM_AW-1:0] memOff  [DEPTH];
  logic [15:0]        memData [DEPTH];
  logic               memUb   [DEPTH];
  logic               memLb   [DEPTH];
  logic               memAlt  [DEPTH];
  logic [PW-1:0]      wrPtr, rdPtr;
  logic [PW:0]        count, countNext;
  logic               qEmpty, isFull, accept, pop, dropped;

  drainState_t state, stateNext;
  logic lowPhase, lowPhaseNext;
  logic useLow, lastByte;
  logic [VRAM_AW-1:0] headAddr;
  logic [7:0]         headByte;
  logic [$bits(vramAddr)-1:0] addrNext;
  logic [7:0] dataNext;
  logic oeNext, weNext;

  // Two-flop synchronisers for the asynchronous bus strobes
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      asMeta  <= 1'b1;
      asSync  <= 1'b1;
      udsMeta <= 1'b1;
      udsSync <= 1'b1;
      ldsMeta <= 1'b1;
      ldsSync <= 1'b1;
    end else begin
      asMeta  <= ncpuAS;
      asSync  <= asMeta;
      udsMeta <= ncpuUDS;
      udsSync <= udsMeta;
      ldsMeta <= ncpuLDS;
      ldsSync <= ldsMeta;
    end
  end

  assign byteAddr = {1'b0, cpuAddr, 1'b0};

  // Screen window decode and VRAM offset of the current bus address
  always_comb begin
    winHit    = (byteAddr >= MAIN_LO) && (byteAddr < MAIN_HI);
    capOffset = VRAM_AW'(byteAddr - MAIN_LO);
    capAlt    = 1'b0;
`ifdef SEVGA_ALTBUF_EN
    if ((byteAddr >= ALT_LO) && (byteAddr < ALT_HI)) begin
      winHit    = 1'b1;
      capOffset = VRAM_AW'(byteAddr - ALT_LO);
      capAlt    = 1'b1;
    end else begin
      capAlt    = 1'b0;
    end
`endif
  end

  assign capture = !asSync && (!udsSync || !ldsSync) && !cpuRnW && winHit && armed;

  // One capture per bus cycle: disarm on capture, re-arm once AS is released
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      armed <= 1'b1;
    end else if (capture) begin
      armed <= 1'b0;
    end else if (asSync) begin
      armed <= 1'b1;
    end
  end

  assign qEmpty  = (count == {(PW+1){1'b0}});
  assign isFull  = (count == DEPTH_C);
  assign accept  = capture && (!isFull || pop);
  assign dropped = capture && isFull && !pop;

  // Occupancy bookkeeping
  always_comb begin
    if (accept && !pop) begin
      countNext = count + {{PW{1'b0}}, 1'b1};
    end else if (pop && !accept) begin
      countNext = count - {{PW{1'b0}}, 1'b1};
    end else begin
      countNext = count;
    end
  end

  // FIFO storage, pointers and status flags
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memOff[i]  <= '0;
        memData[i] <= 16'h0000;
        memUb[i]   <= 1'b0;
        memLb[i]   <= 1'b0;
        memAlt[i]  <= 1'b0;
      end
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      qFull     <= 1'b0;
      qOverflow <= 1'b0;
    end else begin
      if (accept) begin
        memOff[wrPtr]  <= capOffset;
        memData[wrPtr] <= cpuData;
        memUb[wrPtr]   <= !udsSync;
        memLb[wrPtr]   <= !ldsSync;
        memAlt[wrPtr]  <= capAlt;
        wrPtr          <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
      end
      count     <= countNext;
      qFull     <= (countNext == DEPTH_C);
      qOverflow <= qOverflow | dropped;
    end
  end

  // Select which byte of the head entry goes out next
  always_comb begin
    useLow   = lowPhase || !memUb[rdPtr];
    lastByte = useLow || !memLb[rdPtr];
    if (useLow) begin
      headAddr = {memOff[rdPtr][VRAM_AW-1:1], 1'b1};
      headByte = memData[rdPtr][7:0];
    end else begin
      headAddr = memOff[rdPtr];
      headByte = memData[rdPtr][15:8];
    end
  end

  // Drain FSM next state and next registered outputs
  always_comb begin
    stateNext    = state;
    lowPhaseNext = lowPhase;
    addrNext     = vramAddr;
    dataNext     = vramData;
    oeNext       = vramDataOE;
    weNext       = nvramWE;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (hSeq == WR_SLOT && !qEmpty) begin
          stateNext = SETUP;
`ifdef SEVGA_ALTBUF_EN
          addrNext  = {memAlt[rdPtr], headAddr};
`else
          addrNext  = headAddr;
`endif
          dataNext  = headByte;
          oeNext    = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      SETUP: begin
        if (hSeq == SLOT1) begin
          stateNext = STROBE;
          weNext    = 1'b0;
        end else begin
          stateNext = SETUP;
        end
      end
      STROBE: begin
        if (hSeq == SLOT2) begin
          stateNext = HOLD;
          weNext    = 1'b1;
        end else begin
          stateNext = STROBE;
        end
      end
      HOLD: begin
        if (hSeq == SLOT3) begin
          stateNext = IDLE;
          oeNext    = 1'b0;
          if (lastByte) begin
            pop          = 1'b1;
            lowPhaseNext = 1'b0;
          end else begin
            lowPhaseNext = 1'b1;
          end
        end else begin
          stateNext = HOLD;
        end
      end
      default: begin
        stateNext    = IDLE;
        lowPhaseNext = 1'b0;
        oeNext       = 1'b0;
        weNext       = 1'b1;
      end
    endcase
  end

  // Drain FSM state and VRAM-side output registers
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      lowPhase   <= 1'b0;
      vramAddr   <= '0;
      vramData   <= 8'h00;
      vramDataOE <= 1'b0;
      nvramWE    <= 1'b1;
    end else begin
      state      <= stateNext;
      lowPhase   <= lowPhaseNext;
      vramAddr   <= addrNext;
      vramData   <= dataNext;
      vramDataOE <= oeNext;
      nvramWE    <= weNext;
    end
  end

endmodule

// File: tb/tb_cpu_wrqueue.sv
// Directed scoreboard bench for cpu_wrqueue: expected VRAM bytes are queued as bus cycles are
// driven and checked against each nvramWE strobe.
`timescale 1ns/1ps
module tb_cpu_wrqueue;
`ifdef SEVGA_ALTBUF_EN
  localparam int AW = 16;
`else
  localparam int AW = 15;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } exp_t;

  logic          pixClk = 1'b0;
  logic          nReset = 1'b0;
  logic [2:0]    hSeq = 3'd0;
  logic [22:0]   cpuAddr = 23'h0;
  logic [15:0]   cpuData = 16'h0;
  logic          ncpuAS = 1'b1, ncpuUDS = 1'b1, ncpuLDS = 1'b1, cpuRnW = 1'b1;
  logic [AW-1:0] vramAddr;
  logic [7:0]    vramData;
  logic          vramDataOE, nvramWE, qFull, qOverflow;

  exp_t sbq[$];
  int   strobeCyc[$];
  int   evals = 0;
  int   fails = 0;
  int   cycle = 0;
  int   writeCount = 0;
  int   wc0;
  logic runSeq = 1'b1;
  logic prevLow = 1'b0;

  cpu_wrqueue dut (
    .pixClk(pixClk), .nReset(nReset), .hSeq(hSeq),
    .cpuAddr(cpuAddr), .cpuData(cpuData),
    .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS), .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW),
    .vramAddr(vramAddr), .vramData(vramData), .vramDataOE(vramDataOE),
    .nvramWE(nvramWE), .qFull(qFull), .qOverflow(qOverflow)
  );

  always #20 pixClk = ~pixClk;

  always @(posedge pixClk) cycle++;

  // Timing generator stand-in: free-running hCount[2:0], or parked at 0
  always @(negedge pixClk) hSeq = runSeq ? hSeq + 3'd1 : 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every nvramWE-low sample must match the head of the scoreboard
  always @(negedge pixClk) begin
    exp_t e;
    if (nReset === 1'b1 && nvramWE === 1'b0) begin
      check("weWidth", {31'b0, prevLow}, 32'd0);
      check("oeAroundWe", {31'b0, vramDataOE}, 32'd1);
      evals++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL unexpectedWrite: observed addr %0h data %0h expected no write", vramAddr, vramData);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("wrAddr", 32'(vramAddr), 32'(e.a));
        check("wrData", 32'(vramData), 32'(e.d));
      end
      strobeCyc.push_back(cycle);
      writeCount++;
    end
    prevLow = (nvramWE === 1'b0);
  end

  // Drive one bus cycle; the independent address/byte model queues expected VRAM writes
  task automatic busWrite(input logic [22:0] addr, input logic [15:0] data, input logic uds,
                          input logic lds, input logic rnw, input int hold, input logic accepted);
    logic [23:0] ba;
    logic [AW-1:0] off;
    ba = {addr, 1'b0};
    if (!rnw && (uds || lds) && accepted && ba >= 24'h3FA700 && ba < 24'h3FFC80) begin
      off = AW'(ba - 24'h3FA700);
      if (uds) sbq.push_back({off, data[15:8]});
      if (lds) sbq.push_back({off | AW'(1), data[7:0]});
    end
    @(negedge pixClk);
    cpuAddr = addr;
    cpuData = data;
    cpuRnW  = rnw;
    @(negedge pixClk);
    ncpuAS  = 1'b0;
    ncpuUDS = !uds;
    ncpuLDS = !lds;
    repeat (hold) @(negedge pixClk);
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
    repeat (4) @(negedge pixClk);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < maxCyc) begin
      @(negedge pixClk);
      n++;
    end
    repeat (12) @(negedge pixClk);
    check("drainDone", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge pixClk);
    check("rstAddr", 32'(vramAddr), 32'd0);
    check("rstData", 32'(vramData), 32'd0);
    check("rstOE", {31'b0, vramDataOE}, 32'd0);
    check("rstWE", {31'b0, nvramWE}, 32'd1);
    check("rstFull", {31'b0, qFull}, 32'd0);
    check("rstOvf", {31'b0, qOverflow}, 32'd0);
    nReset = 1'b1;
    repeat (4) @(negedge pixClk);

    // Word write: upper byte then lower byte one sequence period apart
    strobeCyc.delete();
    busWrite(23'h1FD380, 16'hA55A, 1'b1, 1'b1, 1'b0, 6, 1'b1);
    waitIdle(100);
    check("wordStrobes", 32'(strobeCyc.size()), 32'd2);
    if (strobeCyc.size() == 2) check("wordSpacing", 32'(strobeCyc[1] - strobeCyc[0]), 32'd8);

    // LDS-only write lands on the odd byte
    wc0 = writeCount;
    busWrite(23'h1FD381, 16'h12C3, 1'b0, 1'b1, 1'b0, 6, 1'b1);
    waitIdle(100);
    check("ldsCount", 32'(writeCount - wc0), 32'd1);

    // Window bounds and read cycle: only the last-word UDS write produces a byte
    wc0 = writeCount;
    busWrite(23'h1FD37F, 16'h1111, 1'b1, 1'b1, 1'b0, 6, 1'b1);
    busWrite(23'h1FFE40, 16'h2222, 1'b1, 1'b1, 1'b0, 6, 1'b1);
    busWrite(23'h1FFE3F, 16'h9E00, 1'b1, 1'b0, 1'b0, 6, 1'b1);
    busWrite(23'h1FD390, 16'h3333, 1'b1, 1'b1, 1'b1, 6, 1'b1);
    waitIdle(100);
    repeat (20) @(negedge pixClk);
    check("boundsCount", 32'(writeCount - wc0), 32'd1);

    // Overflow: park the slot, fill the FIFO, drop the fifth word
    runSeq = 1'b0;
    repeat (2) @(negedge pixClk);
    wc0 = writeCount;
    for (int k = 0; k < 5; k++) begin
      busWrite(23'h1FD390 + 23'(k), {8'h10 + 8'(k), 8'h20 + 8'(k)}, 1'b1, 1'b1, 1'b0, 6, k < 4);
      if (k == 3) begin
        check("fullAfter4", {31'b0, qFull}, 32'd1);
        check("noOvfAfter4", {31'b0, qOverflow}, 32'd0);
      end
    end
    check("fullAfter5", {31'b0, qFull}, 32'd1);
    check("ovfAfter5", {31'b0, qOverflow}, 32'd1);
    check("parkedNoWrites", 32'(writeCount - wc0), 32'd0);
    runSeq = 1'b1;
    waitIdle(150);
    check("ovfDrainCount", 32'(writeCount - wc0), 32'd8);
    check("fullCleared", {31'b0, qFull}, 32'd0);
    check("ovfSticky", {31'b0, qOverflow}, 32'd1);

    // Long address strobe: a single push
    wc0 = writeCount;
    busWrite(23'h1FD3A0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 40, 1'b1);
    waitIdle(100);
    repeat (20) @(negedge pixClk);
    check("longAsCount", 32'(writeCount - wc0), 32'd2);

    // Reset while the write strobe is asserted
    busWrite(23'h1FD3B0, 16'hCAFE, 1'b1, 1'b1, 1'b0, 6, 1'b1);
    n = 0;
    while (nvramWE !== 1'b0 && n < 100) begin
      @(posedge pixClk);
      #2;
      n++;
    end
    check("weSeenLow", {31'b0, nvramWE}, 32'd0);
    nReset = 1'b0;
    #1;
    check("asyncRstWE", {31'b0, nvramWE}, 32'd1);
    check("asyncRstOE", {31'b0, vramDataOE}, 32'd0);
    check("asyncRstOvf", {31'b0, qOverflow}, 32'd0);
    sbq.delete();
    wc0 = writeCount;
    repeat (3) @(negedge pixClk);
    nReset = 1'b1;
    repeat (40) @(negedge pixClk);
    check("postRstNoWrites", 32'(writeCount - wc0), 32'd0);
    check("postRstFull", {31'b0, qFull}, 32'd0);
    busWrite(23'h1FD3C0, 16'h0077, 1'b0, 1'b1, 1'b0, 6, 1'b1);
    waitIdle(100);
    repeat (20) @(negedge pixClk);
    check("postRstSingle", 32'(writeCount - wc0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
